// File: rtl/pp_pipeline_accel_prod_requant_if.sv
// Stream bundle for pp_pipeline_accel_prod_requant.
// It carries the operand-pair input stream (s_*) and the requantized pixel output stream (m_*).
interface pp_pipeline_accel_prod_requant_if #(
  parameter int A_W   = 48,
  parameter int B_W   = 42,
  parameter int OUT_W = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [A_W-1:0]        s_a;
  logic signed [B_W-1:0] s_b;
  logic                  m_valid;
  logic                  m_ready;
  logic [OUT_W-1:0]      m_data;

  // Producer of operands and consumer of pixels.
  modport master (
    output s_valid, s_a, s_b, m_ready,
    input  s_ready, m_valid, m_data
  );

  // The requant block.
  modport slave (
    input  s_valid, s_a, s_b, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/pp_pipeline_accel_prod_requant.sv
// Feeds an external pipelined multiplier, tracks beats with a valid shadow, requantizes
// products to unsigned pixels and buffers them in a small FIFO. Optional macro PP_REQUANT_ROUND_EN.
module pp_pipeline_accel_prod_requant #(
  parameter int A_W        = 48,
  parameter int B_W        = 42,
  parameter int PROD_W     = 74,
  parameter int MUL_LAT    = 4,
  parameter int SHIFT      = 40,
  parameter int OUT_W      = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  pp_pipeline_accel_prod_requant_if.slave bus,
  input  logic signed [8:0]        zero_point,
  output logic                     mul_ce,
  output logic [A_W-1:0]           mul_din0,
  output logic signed [B_W-1:0]    mul_din1,
  input  logic signed [PROD_W-1:0] mul_dout,
  output logic [15:0]              sat_cnt
);

  localparam int EXT_W = PROD_W + 1;
  localparam int ZP_W  = PROD_W - SHIFT + 2;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]       FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]       LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic signed [ZP_W-1:0] PIX_MAX  = ZP_W'((1 << OUT_W) - 1);
  localparam logic [15:0]            SAT_MAX  = 16'hFFFF;
`ifdef PP_REQUANT_ROUND_EN
  localparam logic signed [EXT_W-1:0] ROUND_TERM = EXT_W'(1) << (SHIFT - 1);
`endif

  logic                    adv;
  logic                    hs;
  logic                    push;
  logic                    pop;
  logic                    clip;
  logic [MUL_LAT-1:0]      v_q, v_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [OUT_W-1:0]        mem_q [FIFO_DEPTH];
  logic [OUT_W-1:0]        mem_d [FIFO_DEPTH];
  logic [15:0]             sat_q, sat_d;
  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] rnd;
  logic signed [ZP_W-1:0]  scaled;
  logic signed [ZP_W-1:0]  zp_ext;
  logic signed [ZP_W-1:0]  sum;
  logic [OUT_W-1:0]        pix;

  // Advance depends only on the registered FIFO count, so m_ready never reaches s_ready.
  assign adv         = (count_q < FULL_CNT);
  assign mul_ce      = adv;
  assign bus.s_ready = adv;
  assign mul_din0    = bus.s_a;
  assign mul_din1    = bus.s_b;
  assign bus.m_valid = (count_q != '0);
  assign bus.m_data  = mem_q[rd_ptr_q];
  assign sat_cnt     = sat_q;

  // Requantize the product that leaves the multiplier in this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    clip   = 1'b1;
    pix    = '0;
    ext    = {mul_dout[PROD_W-1], mul_dout};
`ifdef PP_REQUANT_ROUND_EN
    rnd    = ext + ROUND_TERM;
`else
    rnd    = ext;
`endif
    scaled = ZP_W'(rnd >>> SHIFT);
    zp_ext = ZP_W'(zero_point);
    sum    = scaled + zp_ext;
    if (sum[ZP_W-1]) begin
      pix = '0;
    end else if (sum > PIX_MAX) begin
      pix = '1;
    end else begin
      pix  = sum[OUT_W-1:0];
      clip = 1'b0;
    end
  end

  // Valid shadow, FIFO bookkeeping and clip counter.
  always_comb begin
    hs       = bus.s_valid & adv;
    push     = adv & v_q[MUL_LAT-1];
    pop      = bus.m_valid & bus.m_ready;
    v_d      = adv ? ((v_q << 1) | MUL_LAT'(hs)) : v_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sat_d    = sat_q;

    if (push) begin
      mem_d[wr_ptr_q] = pix;
      wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (clip && (sat_q != SAT_MAX)) begin
        sat_d = sat_q + 16'd1;
      end
    end

    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q      <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sat_q    <= '0;
      // NOTE: the FIFO storage is tiny and m_data must read 0 after reset, so it is cleared too.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      v_q      <= v_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sat_q    <= sat_d;
      mem_q    <= mem_d;
    end
  end

endmodule
